// File: rtl/fp_normalizer.sv
// fp_normalizer
// Post-add normalization stage for a floating-point datapath. A start pulse
// captures a 26-bit adder result and its biased exponent. The block then moves
// the leading one to bit 24, one bit per cycle, and reports the mantissa, the
// shift that was applied and the corrected exponent with status flags.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   start         request pulse, honoured only in IDLE
//   mantissa_in   [25] carry, [24] hidden one, [2:0] guard/round/sticky
//   exp_in        biased exponent of mantissa_in
//   busy          high whenever the FSM is not in IDLE
//   done          one-cycle pulse, results valid while high
//   normalized    mantissa with leading one at bit 24
//   shift_amount  distance shifted
//   shift_left    1 = left shift, 0 = right shift or none
//   exp_adjust    magnitude of the exponent correction
//   exp_subtract  1 = exponent decreased, 0 = increased / unchanged
//   exp_out       corrected exponent
//   zero          mantissa was zero
//   exp_overflow  exponent saturated at 255
//   exp_underflow exponent clamped at 0
module fp_normalizer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [25:0] mantissa_in,
  input  logic [7:0]  exp_in,
  output logic        busy,
  output logic        done,
  output logic [25:0] normalized,
  output logic [4:0]  shift_amount,
  output logic        shift_left,
  output logic [7:0]  exp_adjust,
  output logic        exp_subtract,
  output logic [7:0]  exp_out,
  output logic        zero,
  output logic        exp_overflow,
  output logic        exp_underflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [25:0] work_r;
  logic [7:0]  exp_r;
  logic [4:0]  cnt_r;

  // Exponent after a one-bit right shift; saturates at 255 (bit 8 = overflow).
  function automatic logic [8:0] exp_inc(input logic [7:0] e);
    logic [8:0] sum;
    sum = {1'b0, e} + 9'd1;
    if (sum >= 9'd255) begin
      exp_inc = {1'b1, 8'd255};
    end else begin
      exp_inc = {1'b0, sum[7:0]};
    end
  endfunction

  // Exponent after n left shifts; n >= e clamps to 0 (bit 8 = underflow).
  function automatic logic [8:0] exp_dec(input logic [7:0] e, input logic [4:0] n);
    if ({3'd0, n} >= e) begin
      exp_dec = {1'b1, 8'd0};
    end else begin
      exp_dec = {1'b0, e - {3'd0, n}};
    end
  endfunction

  logic [8:0] inc_s;
  logic [8:0] dec_s;

  // Exponent candidates for the carry and left-shift outcomes.
  always_comb begin
    inc_s = exp_inc(exp_r);
    dec_s = exp_dec(exp_r, cnt_r);
  end

  // Control FSM with all results registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      work_r        <= 26'd0;
      exp_r         <= 8'd0;
      cnt_r         <= 5'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      normalized    <= 26'd0;
      shift_amount  <= 5'd0;
      shift_left    <= 1'b0;
      exp_adjust    <= 8'd0;
      exp_subtract  <= 1'b0;
      exp_out       <= 8'd0;
      zero          <= 1'b0;
      exp_overflow  <= 1'b0;
      exp_underflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            work_r        <= mantissa_in;
            exp_r         <= exp_in;
            cnt_r         <= 5'd0;
            zero          <= 1'b0;
            exp_overflow  <= 1'b0;
            exp_underflow <= 1'b0;
            busy          <= 1'b1;
            state_r       <= NORM;
          end else begin
            state_r <= IDLE;
          end
        end
        NORM: begin
          if (work_r == 26'd0) begin
            normalized   <= 26'd0;
            shift_amount <= 5'd0;
            shift_left   <= 1'b0;
            exp_adjust   <= 8'd0;
            exp_subtract <= 1'b0;
            exp_out      <= 8'd0;
            zero         <= 1'b1;
            done         <= 1'b1;
            state_r      <= DONE;
          end else if (work_r[25]) begin
            // Right shift by one; the dropped bit folds into sticky.
            normalized   <= {1'b0, work_r[25:2], work_r[1] | work_r[0]};
            shift_amount <= 5'd1;
            shift_left   <= 1'b0;
            exp_adjust   <= 8'd1;
            exp_subtract <= 1'b0;
            exp_out      <= inc_s[7:0];
            exp_overflow <= inc_s[8];
            done         <= 1'b1;
            state_r      <= DONE;
          end else if (work_r[24]) begin
            normalized   <= work_r;
            shift_amount <= cnt_r;
            exp_adjust   <= {3'd0, cnt_r};
            done         <= 1'b1;
            state_r      <= DONE;
            if (cnt_r == 5'd0) begin
              shift_left   <= 1'b0;
              exp_subtract <= 1'b0;
              exp_out      <= exp_r;
            end else begin
              shift_left    <= 1'b1;
              exp_subtract  <= 1'b1;
              exp_out       <= dec_s[7:0];
              exp_underflow <= dec_s[8];
            end
          end else begin
            work_r  <= {work_r[24:0], 1'b0};
            cnt_r   <= cnt_r + 5'd1;
            state_r <= NORM;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed testbench for fp_normalizer with hand-computed expectations.
module tb_fp_normalizer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [25:0] mantissa_in;
  logic [7:0]  exp_in;
  logic        busy;
  logic        done;
  logic [25:0] normalized;
  logic [4:0]  shift_amount;
  logic        shift_left;
  logic [7:0]  exp_adjust;
  logic        exp_subtract;
  logic [7:0]  exp_out;
  logic        zero;
  logic        exp_overflow;
  logic        exp_underflow;

  int compared;
  int mismatched;

  fp_normalizer dut (
    .clk(clk), .reset(reset), .start(start), .mantissa_in(mantissa_in),
    .exp_in(exp_in), .busy(busy), .done(done), .normalized(normalized),
    .shift_amount(shift_amount), .shift_left(shift_left),
    .exp_adjust(exp_adjust), .exp_subtract(exp_subtract), .exp_out(exp_out),
    .zero(zero), .exp_overflow(exp_overflow), .exp_underflow(exp_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".outs"}, {6'd0, normalized}, 32'd0);
    chk({tag, ".misc"},
        {5'd0, shift_amount, shift_left, exp_adjust, exp_subtract, exp_out,
         zero, exp_overflow, exp_underflow}, 32'd0);
  endtask

  // Issue one operation, optionally re-pulsing start at NORM edge inject_at.
  task automatic run_op(input string tag, input logic [25:0] m, input logic [7:0] e,
                        input int inject_at, input int exp_lat,
                        input logic [25:0] e_norm, input logic [4:0] e_sa,
                        input logic e_sl, input logic [7:0] e_adj, input logic e_sub,
                        input logic [7:0] e_eo, input logic e_z, input logic e_o,
                        input logic e_u);
    int lat;
    @(negedge clk);
    mantissa_in = m;
    exp_in      = e;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busy_after_start"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (lat == inject_at) begin
        start       = 1'b1;
        mantissa_in = 26'h0000003;
        exp_in      = 8'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".normalized"}, {6'd0, normalized}, {6'd0, e_norm});
    chk({tag, ".shift_amount"}, {27'd0, shift_amount}, {27'd0, e_sa});
    chk({tag, ".shift_left"}, {31'd0, shift_left}, {31'd0, e_sl});
    chk({tag, ".exp_adjust"}, {24'd0, exp_adjust}, {24'd0, e_adj});
    chk({tag, ".exp_subtract"}, {31'd0, exp_subtract}, {31'd0, e_sub});
    chk({tag, ".exp_out"}, {24'd0, exp_out}, {24'd0, e_eo});
    chk({tag, ".flags"}, {29'd0, zero, exp_overflow, exp_underflow},
        {29'd0, e_z, e_o, e_u});
    @(posedge clk);
    #1;
    chk({tag, ".done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    chk({tag, ".hold_exp"}, {24'd0, exp_out}, {24'd0, e_eo});
  endtask

  initial begin
    int saw_done;
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b1;
    start       = 1'b1;
    mantissa_in = 26'h2000003;
    exp_in      = 8'd128;

    // Reset held two cycles with start high: nothing may begin.
    @(posedge clk);
    #1;
    chk_all_zero("reset1");
    @(posedge clk);
    #1;
    chk_all_zero("reset2");
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("post_reset");

    run_op("carry", 26'h2000003, 8'd128, 0, 1, 26'h1000001, 5'd1, 1'b0, 8'd1,
           1'b0, 8'd129, 1'b0, 1'b0, 1'b0);
    run_op("deep", 26'h0000008, 8'd127, 0, 22, 26'h1000000, 5'd21, 1'b1, 8'd21,
           1'b1, 8'd106, 1'b0, 1'b0, 1'b0);
    run_op("zero", 26'h0000000, 8'd50, 0, 1, 26'h0000000, 5'd0, 1'b0, 8'd0,
           1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    run_op("uflow", 26'h0000001, 8'd10, 0, 25, 26'h1000000, 5'd24, 1'b1, 8'd24,
           1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    run_op("oflow", 26'h2000000, 8'd254, 0, 1, 26'h1000000, 5'd1, 1'b0, 8'd1,
           1'b0, 8'd255, 1'b0, 1'b1, 1'b0);
    run_op("noshift", 26'h1000005, 8'd77, 0, 1, 26'h1000005, 5'd0, 1'b0, 8'd0,
           1'b0, 8'd77, 1'b0, 1'b0, 1'b0);

    // Abort: reset five cycles into a 16-shift operation.
    @(negedge clk);
    mantissa_in = 26'h0000100;
    exp_in      = 8'd100;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("abort");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1;
    end
    chk("abort.no_done", saw_done, 0);

    // Re-issue with a stray start during NORM that must be ignored.
    run_op("reissue", 26'h0000100, 8'd100, 3, 17, 26'h1000000, 5'd16, 1'b1, 8'd16,
           1'b1, 8'd84, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
